// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared access-size encodings and helpers for byte_ram_2p.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  localparam int MEM_DEPTH = 1024;
  localparam int IDX_W     = $clog2(MEM_DEPTH);

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      SZ_B:    n = 4'd1;
      SZ_H:    n = 4'd2;
      SZ_W:    n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_clear_seq
//  Description : Post-reset sequencer that walks every byte address once,
//                then parks in RUN and reports ready.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             clr_en_o,
  output logic [CNT_W-1:0] clr_addr_o,
  output logic             ready_o
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } seq_state_e;

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(DEPTH - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == c_last_idx) w_state_nxt = ST_RUN;
      end
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  assign clr_en_o   = (r_state == ST_CLEAR);
  assign clr_addr_o = r_cnt;
  assign ready_o    = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: rtl/byte_ram_2p.sv
`default_nettype none
// ============================================================================
//  Module      : byte_ram_2p
//  Description : Little-endian byte RAM with a read-only fetch port and a
//                sized read/write data port; registered, bounds-checked.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_ram_2p
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 64,
  parameter int DW    = 64,
  parameter int IW    = 80
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          ready_o,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [IW-1:0] if_rdata_o,
  output logic          if_valid_o,
  output logic          if_error_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [1:0]    d_size_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_valid_o,
  output logic          d_error_o
);

  localparam int          ADDR_W    = $clog2(DEPTH);
  localparam int          FB        = IW / 8;
  localparam logic [AW:0] c_last    = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] c_if_span = (AW+1)'(FB - 1);

  logic [7:0] r_mem [DEPTH];

  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_ready;

  mem_clear_seq #(
    .DEPTH (DEPTH),
    .CNT_W (ADDR_W)
  ) u_clear_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_en_o   (w_clr_en),
    .clr_addr_o (w_clr_addr),
    .ready_o    (w_ready)
  );

  assign ready_o = w_ready;

  logic [3:0]        w_d_n;
  logic [AW:0]       w_d_last;
  logic [AW:0]       w_if_last;
  logic              w_d_err;
  logic              w_if_err;
  logic              w_d_fire;
  logic              w_if_fire;
  logic              w_d_wr;
  logic [ADDR_W-1:0] w_d_idx;
  logic [ADDR_W-1:0] w_if_idx;
  logic [DW-1:0]     w_d_gather;
  logic [IW-1:0]     w_if_gather;

  // One extra bit keeps a wrapped end address distinguishable from a small one
  assign w_d_n     = size_bytes(d_size_i);
  assign w_d_last  = {1'b0, d_addr_i} + (AW+1)'(w_d_n) - (AW+1)'(1);
  assign w_if_last = {1'b0, if_addr_i} + c_if_span;
  assign w_d_err   = (w_d_last > c_last);
  assign w_if_err  = (w_if_last > c_last);

  assign w_d_fire  = d_req_i & w_ready;
  assign w_if_fire = if_req_i & w_ready;
  assign w_d_wr    = w_d_fire & d_we_i & ~w_d_err;
  assign w_d_idx   = d_addr_i[ADDR_W-1:0];
  assign w_if_idx  = if_addr_i[ADDR_W-1:0];

  always_comb begin
    w_d_gather = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < w_d_n) w_d_gather[8*k +: 8] = r_mem[w_d_idx + ADDR_W'(k)];
    end
  end

  always_comb begin
    w_if_gather = '0;
    for (int k = 0; k < FB; k++) begin
      w_if_gather[8*k +: 8] = r_mem[w_if_idx + ADDR_W'(k)];
    end
  end

  // Gathers above sample pre-edge contents, so a same-cycle write is not seen
  always_ff @(posedge clk_i) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_d_wr) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < w_d_n) r_mem[w_d_idx + ADDR_W'(k)] <= d_wdata_i[8*k +: 8];
      end
    end
  end

  logic [DW-1:0] r_d_rdata;
  logic          r_d_valid;
  logic          r_d_error;
  logic [IW-1:0] r_if_rdata;
  logic          r_if_valid;
  logic          r_if_error;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_d_rdata  <= '0;
      r_d_valid  <= 1'b0;
      r_d_error  <= 1'b0;
      r_if_rdata <= '0;
      r_if_valid <= 1'b0;
      r_if_error <= 1'b0;
    end else begin
      r_d_valid  <= w_d_fire;
      r_d_error  <= w_d_fire & w_d_err;
      r_if_valid <= w_if_fire;
      r_if_error <= w_if_fire & w_if_err;
      if (w_d_fire)  r_d_rdata  <= (d_we_i | w_d_err) ? '0 : w_d_gather;
      if (w_if_fire) r_if_rdata <= w_if_err ? '0 : w_if_gather;
    end
  end

  assign d_rdata_o  = r_d_rdata;
  assign d_valid_o  = r_d_valid;
  assign d_error_o  = r_d_error;
  assign if_rdata_o = r_if_rdata;
  assign if_valid_o = r_if_valid;
  assign if_error_o = r_if_error;

endmodule
`default_nettype wire

// File: tb/tb_byte_ram_2p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_ram_2p
//  Description : Scoreboard bench for byte_ram_2p against a byte-array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_byte_ram_2p;

  localparam int DEPTH = 1024;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int IW    = 80;
  localparam int FB    = IW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ready_o;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [IW-1:0] if_rdata_o;
  logic          if_valid_o;
  logic          if_error_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [1:0]    d_size_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_valid_o;
  logic          d_error_o;

  always #5 clk_i = ~clk_i;

  byte_ram_2p #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .IW(IW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ready_o    (ready_o),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_valid_o (if_valid_o),
    .if_error_o (if_error_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_size_i   (d_size_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_rdata_o  (d_rdata_o),
    .d_valid_o  (d_valid_o),
    .d_error_o  (d_error_o)
  );

  typedef struct packed { logic [DW-1:0] data; logic err; } exp_d_t;
  typedef struct packed { logic [IW-1:0] data; logic err; } exp_i_t;

  exp_d_t q_d[$];
  exp_i_t q_i[$];
  logic [7:0] ref_mem [DEPTH];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever a response strobe appears
  exp_d_t        m_ed;
  exp_i_t        m_ei;
  logic [DW-1:0] hold_d = '0;
  logic [IW-1:0] hold_i = '0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      hold_d = '0;
      hold_i = '0;
    end else begin
      if (d_valid_o) begin
        if (q_d.size() == 0) chk("d_unexpected_valid", d_valid_o, 1'b0);
        else begin
          m_ed = q_d.pop_front();
          chk("d_rdata", d_rdata_o, m_ed.data);
          chk("d_error", d_error_o, m_ed.err);
          hold_d = m_ed.data;
        end
      end else begin
        chk("d_rdata_hold", d_rdata_o, hold_d);
        chk("d_error_idle", d_error_o, 1'b0);
      end
      if (if_valid_o) begin
        if (q_i.size() == 0) chk("if_unexpected_valid", if_valid_o, 1'b0);
        else begin
          m_ei = q_i.pop_front();
          chk("if_rdata", if_rdata_o, m_ei.data);
          chk("if_error", if_error_o, m_ei.err);
          hold_i = m_ei.data;
        end
      end else begin
        chk("if_rdata_hold", if_rdata_o, hold_i);
        chk("if_error_idle", if_error_o, 1'b0);
      end
    end
  end

  function automatic exp_i_t model_fetch(input logic [AW-1:0] a);
    exp_i_t e;
    e.data = '0;
    e.err  = (a > 64'(DEPTH - FB));
    if (!e.err)
      for (int k = 0; k < FB; k++) e.data[8*k +: 8] = ref_mem[int'(a[15:0]) + k];
    return e;
  endfunction

  // Drive one cycle of stimulus; expectations reflect memory before this edge
  task automatic step(input bit do_i, input logic [AW-1:0] ia,
                      input bit do_d, input bit we, input logic [1:0] sz,
                      input logic [AW-1:0] da, input logic [DW-1:0] wd);
    exp_d_t ed;
    int n;
    if_req_i  = do_i;
    if_addr_i = ia;
    d_req_i   = do_d;
    d_we_i    = we;
    d_size_i  = sz;
    d_addr_i  = da;
    d_wdata_i = wd;
    if (ready_o) begin
      if (do_i) q_i.push_back(model_fetch(ia));
      if (do_d) begin
        n = 1 << sz;
        ed.err  = (da > 64'(DEPTH - n));
        ed.data = '0;
        if (!ed.err) begin
          for (int k = 0; k < n; k++) begin
            if (we) ref_mem[int'(da[15:0]) + k] = wd[8*k +: 8];
            else    ed.data[8*k +: 8] = ref_mem[int'(da[15:0]) + k];
          end
        end
        q_d.push_back(ed);
      end
    end
    @(posedge clk_i); #1;
    if_req_i = 1'b0;
    d_req_i  = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int already);
    int cnt;
    cnt = already;
    while (!ready_o && cnt < 3000) begin
      @(posedge clk_i); #1;
      cnt++;
    end
    chk(name, 32'(cnt), 32'd1024);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 64'($urandom_range(0, 63));
      2:       return 64'($urandom_range(0, DEPTH - 1));
      3:       return 64'(DEPTH - 16 + $urandom_range(0, 23));
      4:       return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(0, 1) == 1, rand_addr(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), rand_addr(), {$urandom, $urandom});
  endtask

  initial begin
    rst_i     = 1'b1;
    if_req_i  = 1'b0;
    if_addr_i = '0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_size_i  = 2'd0;
    d_addr_i  = '0;
    d_wdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_d_valid", d_valid_o, 1'b0);
    chk("rst_if_valid", if_valid_o, 1'b0);
    chk("rst_d_rdata", d_rdata_o, 64'h0);
    chk("rst_if_rdata", if_rdata_o, 80'h0);
    rst_i = 1'b0;
    wait_ready("ready_latency", 0);

    step(1, 64'd500, 1, 0, 2'd3, 64'd0, '0);
    step(0, '0, 1, 1, 2'd3, 64'd8, 64'h1122334455667788);
    step(0, '0, 1, 0, 2'd0, 64'd9, '0);
    step(0, '0, 1, 0, 2'd1, 64'd14, '0);
    step(1, 64'd1014, 1, 0, 2'd3, 64'd1016, '0);
    step(1, 64'd1015, 1, 0, 2'd3, 64'd1017, '0);
    step(0, '0, 1, 1, 2'd3, 64'd1017, 64'hDEAD_BEEF_CAFE_F00D);
    step(0, '0, 1, 0, 2'd3, 64'd1016, '0);
    step(0, '0, 1, 1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, '0, 1, 0, 2'd2, 64'd0, '0);
    step(1, 64'd8, 1, 1, 2'd0, 64'd8, 64'hAA);
    step(1, 64'd8, 0, 0, 2'd0, '0, '0);
    random_phase(800);
    repeat (2) @(posedge clk_i);
    #1;

    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (300) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    step(1, 64'd0, 1, 1, 2'd3, 64'd0, 64'h0123_4567_89AB_CDEF);
    chk("clear_no_d_valid", d_valid_o, 1'b0);
    chk("clear_no_if_valid", if_valid_o, 1'b0);
    wait_ready("ready_latency_restart", 1);
    step(1, 64'd0, 1, 0, 2'd3, 64'd0, '0);
    random_phase(200);

    repeat (3) @(posedge clk_i);
    #1;
    chk("d_queue_drained", 32'(q_d.size()), 32'd0);
    chk("if_queue_drained", 32'(q_i.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_ram_2p.md
Name: byte_ram_2p

Overview:
- Parametrised successor to the CPU's flat byte-addressed memory.
- Little-endian byte array with two ports:
  - instruction fetch port: read-only, fixed IW-bit fetch;
  - data port: read/write, 1/2/4/8-byte access sizes.
- Reads are registered: 1-cycle latency with a valid strobe, and the bounds check is exact.
- After reset, an internal clear sequencer zeroes the array, replacing the combinational for-loop clear.

Parameters:
- DEPTH, 1024, number of bytes in the array (power of two, ≥16).
- AW, 64, address port width.
- DW, 64, data port width (must be 64).
- IW, 80, fetch width in bits (multiple of 8, ≤128).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- ready_o  out  1  high once the clear sequence has completed.
- if_req_i  in  1  fetch request.
- if_addr_i  in  AW  fetch byte address.
- if_rdata_o  out  IW  fetched bytes; byte at if_addr in bits [7:0].
- if_valid_o  out  1  fetch response strobe.
- if_error_o  out  1  fetch out-of-range; qualified by if_valid_o.
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = write, 0 = read.
- d_size_i  in  2  0=1B, 1=2B, 2=4B, 3=8B.
- d_addr_i  in  AW  data byte address.
- d_wdata_i  in  DW  write data; low 2^size bytes used.
- d_rdata_o  out  DW  read data, zero-extended.
- d_valid_o  out  1  data response strobe (reads and writes).
- d_error_o  out  1  data out-of-range; qualified by d_valid_o.

Behaviour:
- Reset (asynchronous):
  - ready_o=0, all valids and errors 0, rdata outputs 0.
  - Sequencer enters CLEAR with counter 0.
  - The array itself is not reset asynchronously.
- Sequencer FSM:
  - CLEAR: write 0 to byte[counter]; counter+1 each cycle. At counter = DEPTH-1, go to RUN. Total DEPTH cycles.
  - RUN: ready_o=1. Terminal state until the next reset.
  - Reset asserted mid-CLEAR or in RUN restarts CLEAR from 0.
- Requests while ready_o=0 are dropped: no response, no write.
- Bounds check:
  - n = 2^size for data, IW/8 for fetch.
  - Error when addr + n - 1 > DEPTH-1, computed in AW+1 bits so address wrap-around is flagged, never aliased.
  - No alignment requirement.
- Data read:
  - Request in cycle T → d_valid_o=1 in T+1.
  - d_rdata_o = bytes addr..addr+n-1 little-endian, upper bits 0.
  - On error: rdata=0, d_error_o=1.
- Data write:
  - Bytes are updated at the clock edge of cycle T.
  - d_valid_o=1 in T+1, d_rdata_o=0.
  - On error: no byte is modified, d_error_o=1.
- Fetch:
  - Request in T → if_valid_o=1 in T+1 with IW/8 bytes.
  - On error: if_rdata_o=0, if_error_o=1.
- Valid and error outputs are single-cycle pulses. rdata holds its last value when valid=0.
- Same-cycle fetch and data write on overlapping bytes: fetch returns pre-write data (read-before-write).
- Same-cycle data read and fetch are independent. Back-to-back requests every cycle are supported, giving full throughput on both ports.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - function size_bytes(size);
  - localparam IDX_W = $clog2(DEPTH).
- Sub-module mem_clear_seq holds the CLEAR/RUN FSM and counter. It outputs clr_en, clr_addr and ready.
- The top level owns the array, both read pipelines, bounds check and write merge.

Test Plan:
- Reset, then wait → ready_o stays 0 for exactly 1024 cycles, then 1. An 8B read at 0 and a fetch at 500 both return 0.
- Write size=3, addr=8, data 0x1122334455667788. Read size=0 at addr 9 → d_rdata_o=0x77 in the cycle after the request. Read size=1 at addr 14 → 0x1122.
- 8B data read at 1016 → d_valid_o=1, d_error_o=0. At 1017 → d_error_o=1, rdata 0, no memory change. Fetch at 1014 → ok; fetch at 1015 → if_error_o=1.
- Write addr=0xFFFF_FFFF_FFFF_FFFC size=3 → d_error_o=1; bytes 0..3 remain 0 (no wrap aliasing).
- Same cycle: fetch at 8 and write 0xAA size=0 at 8 → fetched byte0 is the old value. A refetch next cycle returns 0xAA.
- Assert rst_i at clear counter 300 for one cycle → ready_o returns 1024 cycles after deassert. A request during CLEAR produces no valid pulse.
